matmult_result_collector: RTL and testbench
===========================================

Name: matmult_result_collector

Overview:
- Sits on the write side of the matrix-multiply kernel. It issues the kernel's one-cycle Start pulse, then captures every C result the kernel writes (Wr_en/Wr_addr/C) into an internal result buffer.
- Once all results are captured, it drains them in address order over a valid/ready stream to the host/DMA side, then reports completion.

Parameters:
- DATA_W, 32, width of C results and of Out_data (matches kernel output width).
- ADDR_W, 8, width of Wr_addr.
- NUM_RES, 250, number of results per run (kernel EXECYCLE-6); buffer depth; must be ≤ 2^ADDR_W.

Ports:
- Clk  input  1  rising-edge clock, shared with kernel.
- Rst_n  input  1  asynchronous active-low reset.
- Go  input  1  host request to start a run; sampled only in IDLE.
- Start  output  1  one-cycle start pulse to kernel.
- Wr_en  input  1  kernel result-write strobe.
- Wr_addr  input  ADDR_W  kernel result address.
- C  input  DATA_W  kernel result data.
- Out_valid  output  1  stream data valid.
- Out_ready  input  1  stream consumer ready.
- Out_data  output  DATA_W  stream result data.
- Out_last  output  1  high with final result (index NUM_RES-1).
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle pulse after the last stream handshake.
- Err  output  1  sticky protocol-error flag; cleared only by reset or the next accepted Go.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Rst_n). While Rst_n=0, all outputs are 0, state is IDLE, counters are 0. Buffer contents are not reset.
- States: IDLE, KICK, COLLECT, DRAIN.
- IDLE:
  - Go=1 → KICK; clear Err and the write counter.
  - Wr_en=1 in IDLE → data ignored, Err←1.
- KICK: Start=1 for exactly this one cycle → COLLECT. Busy=1 from KICK onward.
- COLLECT:
  - Each cycle with Wr_en=1 and Wr_addr<NUM_RES: buf[Wr_addr]←C, wr_cnt←wr_cnt+1.
  - Wr_en=1 with Wr_addr≥NUM_RES: no store, no count, Err←1.
  - Duplicate addresses are counted (not detected).
  - When a counted write brings wr_cnt to NUM_RES → DRAIN on the next edge. No further writes are expected.
  - Go is ignored in COLLECT.
- DRAIN:
  - Buffer read is synchronous (1 cycle). Out_valid rises at most 2 cycles after DRAIN entry.
  - Stream order is indices 0..NUM_RES-1. rd_idx advances only on Out_valid&Out_ready.
  - Out_data/Out_last are registered and stable while Out_valid=1 and Out_ready=0.
  - Out_valid, once asserted, is not dropped before handshake.
  - Throughput: one result per cycle with Out_ready held 1 (prefetch the next entry so there are no bubbles).
  - Out_last=1 only with index NUM_RES-1.
  - On the last handshake: Out_valid←0, Done=1 for one cycle, → IDLE.
  - Wr_en=1 in DRAIN → ignored, Err←1. Go ignored.
- Simultaneous events:
  - Go in the same cycle as the Done pulse is not accepted, because state is still DRAIN.
  - Go on the first IDLE cycle is accepted.
- Reset mid-operation: immediate return to IDLE; the partial run is discarded; Start is never glitched high.
- Widths: wr_cnt and rd_idx are sized ceil(log2(NUM_RES+1)) bits and do not wrap.

Optional Feature:
- Macro: MATMULT_COLLECT_CHECKSUM_EN.
- Defined:
  - Adds output Checksum [DATA_W-1:0] (reset 0, cleared on accepted Go).
  - Checksum accumulates C of every counted write, modulo 2^DATA_W.
  - Value is final and stable from the Done pulse until the next accepted Go.
- Undefined: no Checksum port, no accumulator logic.

Test Plan:
- NUM_RES=4; Go pulse; kernel writes addr 0..3 with C=10,20,30,40, Out_ready=1 → exactly one Start pulse 1 cycle after Go; stream 10,20,30,40 on consecutive cycles, Out_last on 40; Done 1 cycle later; Err=0.
- Writes in order 3,1,0,2 with C=0xD,0xB,0xA,0xC → stream 0xA,0xB,0xC,0xD in index order.
- Out_ready toggled 1,0,0,1,0,1,1 during drain → no result dropped or duplicated; Out_data held stable on every stalled cycle.
- Write to addr 7 during COLLECT, then valid addrs 0..3 → Err=1; stream still contains only the 4 valid results; next Go clears Err.
- Assert Rst_n=0 after 2 of 4 writes, release, issue Go, then full run → Busy=0 and all outputs 0 during reset; the new run completes normally.
- Checksum macro defined, C = 0xFFFFFFFF, 1, 5, 7 (DATA_W=32) → Checksum=0x0000000C at Done.

Source files
------------

// File: rtl/matmult_result_collector.sv
// Result collector for the matrix-multiply kernel: kicks the kernel, buffers its C writes, then
// streams them out in address order. Optional MATMULT_COLLECT_CHECKSUM_EN adds a Checksum output.
module matmult_result_collector #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned NUM_RES = 250
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Go,
  output logic              Start,
  input  logic              Wr_en,
  input  logic [ADDR_W-1:0] Wr_addr,
  input  logic [DATA_W-1:0] C,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_last,
  output logic              Busy,
  output logic              Done,
  output logic              Err
`ifdef MATMULT_COLLECT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_RES + 1);
  localparam int unsigned IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

  typedef enum logic [1:0] {StIdle, StKick, StCollect, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  rd_addr;
  logic [IDX_W-1:0]  rd_sel, wr_sel;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [NUM_RES];
  logic              wr_in_range, wr_count, hs, last_hs, go_acc;

  always_comb begin
    wr_in_range = 32'(Wr_addr) < NUM_RES;
    wr_count    = (state_q == StCollect) && Wr_en && wr_in_range;
    hs          = out_valid_q && Out_ready;
    last_hs     = hs && out_last_q;
    go_acc      = (state_q == StIdle) && Go;
    wr_sel      = Wr_addr[IDX_W-1:0];
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN holds one extra cycle so Done is raised while still busy
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (Go) state_d = StKick;
      StKick:    state_d = StCollect;
      StCollect: if (wr_count && (wr_cnt_q == CNT_W'(NUM_RES - 1))) state_d = StDrain;
      StDrain:   if (done_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    Start     = (state_q == StKick);
    Busy      = (state_q != StIdle);
    Out_valid = out_valid_q;
    Out_data  = rd_data_q;
    Out_last  = out_last_q;
    Done      = done_q;
    Err       = err_q;
  end

  // Datapath next-state; rd_addr is the index presented on the following cycle, which keeps the
  // synchronous read one step ahead of the handshake so a held-ready stream has no bubbles.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (go_acc) begin
      wr_cnt_d = '0;
    end else if (wr_count) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    rd_addr  = hs ? (rd_idx_q + CNT_W'(1)) : rd_idx_q;
    rd_sel   = (32'(rd_addr) < NUM_RES) ? rd_addr[IDX_W-1:0] : '0;
    rd_idx_d = (last_hs || go_acc) ? '0 : rd_addr;

    out_valid_d = out_valid_q;
    if (state_q == StDrain) begin
      if (last_hs) begin
        out_valid_d = 1'b0;
      end else if (!out_valid_q && !done_q) begin
        out_valid_d = 1'b1;
      end
    end

    out_last_d = (state_q == StDrain) && !last_hs && !done_q &&
                 (rd_addr == CNT_W'(NUM_RES - 1));
    done_d     = last_hs;

    err_d = err_q;
    if (go_acc) begin
      err_d = 1'b0;
    end
    if (Wr_en && ((state_q != StCollect) || !wr_in_range)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_data_q   <= mem[rd_sel];
    end
  end

  // Result buffer is not reset
  always_ff @(posedge Clk) begin
    if (wr_count) begin
      mem[wr_sel] <= C;
    end
  end

`ifdef MATMULT_COLLECT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (go_acc) begin
      sum_d = '0;
    end else if (wr_count) begin
      sum_d = sum_q + C;
    end
    Checksum = sum_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_matmult_result_collector.sv
// Bench for matmult_result_collector (NUM_RES=4): reference model of the captured buffer and
// stream order, checked every cycle, with random data/orders/backpressure.
module tb_matmult_result_collector;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] c = '0;
  logic          out_ready = 1'b0;
  logic          start, out_valid, out_last, busy, done, err;
  logic [DW-1:0] out_data;
`ifdef MATMULT_COLLECT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  matmult_result_collector #(.DATA_W(DW), .ADDR_W(AW), .NUM_RES(N)) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Go       (go),
    .Start    (start),
    .Wr_en    (wr_en),
    .Wr_addr  (wr_addr),
    .C        (c),
    .Out_valid(out_valid),
    .Out_ready(out_ready),
    .Out_data (out_data),
    .Out_last (out_last),
    .Busy     (busy),
    .Done     (done),
    .Err      (err)
`ifdef MATMULT_COLLECT_CHECKSUM_EN
    ,
    .Checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [DW-1:0] exp_mem [N];
  bit            exp_err;
  logic [DW-1:0] exp_sum;
  int            hs_idx;
  bit            done_due;
  bit            run_done;
  int            start_cnt;
  int            cyc;
  logic [DW-1:0] got_q [$];
  int            hs_cyc [$];
  bit            stalled;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected", name);
  endtask

  // Compare process
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stalled  = 1'b0;
      done_due = 1'b0;
    end else begin
      if (start) start_cnt++;
      if (done_due || done) begin
        check("done_pulse", done, done_due);
        if (done) begin
          run_done = 1'b1;
`ifdef MATMULT_COLLECT_CHECKSUM_EN
          check("checksum_at_done", checksum, exp_sum);
`endif
        end
        done_due = 1'b0;
      end
      if (stalled) begin
        check("valid_held", out_valid, 1);
        if (out_valid) begin
          check("data_held", out_data, held_data);
          check("last_held", out_last, held_last);
        end
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (hs_idx >= N) begin
          fail_now("extra_valid");
        end else if (out_ready) begin
          check("stream_data", out_data, exp_mem[hs_idx]);
          check("stream_last", out_last, (hs_idx == N - 1));
          got_q.push_back(out_data);
          hs_cyc.push_back(cyc);
          if (hs_idx == N - 1) done_due = 1'b1;
          hs_idx++;
        end else begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start_cnt = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    exp_err  = 1'b0;
    exp_sum  = '0;
    hs_idx   = 0;
    run_done = 1'b0;
    got_q.delete();
    hs_cyc.delete();
    check("start_after_go", start, 1);
    check("busy_in_kick", busy, 1);
    check("err_cleared_by_go", err, 0);
    tick();
    check("start_one_cycle", start, 0);
  endtask

  task automatic write(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    c       = data;
    if (addr < N) begin
      exp_mem[addr] = data;
      exp_sum       = exp_sum + data;
    end else begin
      exp_err = 1'b1;
    end
    tick();
    wr_en = 1'b0;
  endtask

  // mode 0: ready held high, 1: fixed toggle pattern, 2: random
  task automatic drain(input int mode);
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int k = 0;
    while (!run_done && k < 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[k % 7];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      k++;
    end
    out_ready = 1'b0;
    if (!run_done) fail_now("drain_timeout");
    check("run_count", hs_idx, N);
    check("start_count", start_cnt, 1);
    check("busy_after_done", busy, 0);
    check("err_after_run", err, exp_err);
  endtask

  task automatic reset_zero_check(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [DW-1:0] lit [N];
    int            perm [N];
    int            j, t;

    tick();
    tick();
    reset_zero_check("reset");
    rst_n = 1'b1;
    tick();

    // Basic in-order run with literal expectations
    start_run();
    write(0, 10); write(1, 20); write(2, 30); write(3, 40);
    out_ready = 1'b1;
    tick();
    tick();
    check("valid_within_2", out_valid, 1);
    drain(0);
    lit = '{10, 20, 30, 40};
    check("lit1_size", got_q.size(), N);
    if (got_q.size() == N) begin
      for (int i = 0; i < N; i++) check("lit1_data", got_q[i], lit[i]);
      check("back_to_back", hs_cyc[N-1] - hs_cyc[0], N - 1);
    end

    // Out-of-order writes
    start_run();
    write(3, 'hD); write(1, 'hB); write(0, 'hA); write(2, 'hC);
    drain(0);
    lit = '{'hA, 'hB, 'hC, 'hD};
    check("lit2_size", got_q.size(), N);
    if (got_q.size() == N) for (int i = 0; i < N; i++) check("lit2_data", got_q[i], lit[i]);

    // Backpressure pattern
    start_run();
    for (int i = 0; i < N; i++) write(i, $urandom);
    drain(1);
    check("stall_size", got_q.size(), N);

    // Out-of-range write sets Err, stream unaffected
    start_run();
    write(7, 'h77);
    for (int i = 0; i < N; i++) write(i, $urandom);
    drain(0);
    check("err_lit", err, 1);

    // Write in IDLE flags Err; the following Go clears it
    wr_en = 1'b1; wr_addr = 1; c = 'h55;
    tick();
    wr_en = 1'b0;
    check("err_idle_write", err, 1);

    // Reset mid-collect
    start_run();
    write(0, 1); write(1, 2);
    rst_n = 1'b0;
    #2;
    reset_zero_check("midrst");
    tick();
    reset_zero_check("midrst_hold");
    rst_n = 1'b1;
    tick();
    start_run();
    for (int i = 0; i < N; i++) write(i, 100 + i);
    drain(2);

`ifdef MATMULT_COLLECT_CHECKSUM_EN
    start_run();
    write(0, 'hFFFF_FFFF); write(1, 1); write(2, 5); write(3, 7);
    drain(0);
    check("checksum_lit", checksum, 'hC);
`endif

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      start_run();
      if ($urandom_range(0, 3) == 0) write($urandom_range(N, 255), $urandom);
      for (int i = 0; i < N; i++) begin
        write(perm[i], $urandom);
        if ($urandom_range(0, 2) == 0 && i < N - 1) tick();
      end
      drain(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
